// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: drives register file read addresses, bypasses results from
// EX/MEM/WB onto the operands, detects load-use hazards and registers the EX slot.
module id_ex_operand_stage #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ID_VALID,
    input  logic [4:0]        ID_RS1,
    input  logic [4:0]        ID_RS2,
    input  logic              ID_USE_RS1,
    input  logic              ID_USE_RS2,
    input  logic [4:0]        ID_RD,
    input  logic              ID_REG_WRITE,
    input  logic              ID_MEM_READ,
    input  logic [XLEN-1:0]   ID_IMM,
    input  logic [XLEN-1:0]   ID_PC,
    input  logic [CTRL_W-1:0] ID_CTRL,
    output logic [4:0]        READ_REG_1,
    output logic [4:0]        READ_REG_2,
    input  logic [XLEN-1:0]   RF_DATA_1,
    input  logic [XLEN-1:0]   RF_DATA_2,
    input  logic [XLEN-1:0]   EX_ALU_RESULT,
    input  logic              MEM_REG_WRITE,
    input  logic [4:0]        MEM_RD,
    input  logic [XLEN-1:0]   MEM_DATA,
    input  logic              WB_REG_WRITE,
    input  logic [4:0]        WB_RD,
    input  logic [XLEN-1:0]   WB_DATA,
    input  logic              FLUSH,
    output logic              STALL,
    output logic              EX_VALID,
    output logic              EX_REG_WRITE,
    output logic              EX_MEM_READ,
    output logic [4:0]        EX_RD,
    output logic [XLEN-1:0]   EX_OP_A,
    output logic [XLEN-1:0]   EX_OP_B,
    output logic [XLEN-1:0]   EX_IMM,
    output logic [XLEN-1:0]   EX_PC,
    output logic [CTRL_W-1:0] EX_CTRL,
    output logic [CNT_W-1:0]  STALL_COUNT
);

    logic              ex_valid_q, ex_valid_d;
    logic              ex_reg_write_q, ex_reg_write_d;
    logic              ex_mem_read_q, ex_mem_read_d;
    logic [4:0]        ex_rd_q, ex_rd_d;
    logic [XLEN-1:0]   ex_op_a_q, ex_op_a_d;
    logic [XLEN-1:0]   ex_op_b_q, ex_op_b_d;
    logic [XLEN-1:0]   ex_imm_q, ex_imm_d;
    logic [XLEN-1:0]   ex_pc_q, ex_pc_d;
    logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;

    logic [XLEN-1:0]   op_a, op_b;
    logic              haz;

    // Bypass priority: youngest producer first. A load in EX has no data yet, so it
    // is excluded here and handled by the hazard stall instead.
    function automatic logic [XLEN-1:0] sel_operand(
        input logic [4:0]      src,
        input logic [XLEN-1:0] rf_data,
        input logic            ex_fwd_ok,
        input logic [4:0]      ex_rd,
        input logic [XLEN-1:0] ex_data,
        input logic            mem_we,
        input logic [4:0]      mem_rd,
        input logic [XLEN-1:0] mem_data,
        input logic            wb_we,
        input logic [4:0]      wb_rd,
        input logic [XLEN-1:0] wb_data
    );
        if (src == 5'd0) begin
            return '0;
        end else if (ex_fwd_ok && ex_rd == src) begin
            return ex_data;
        end else if (mem_we && mem_rd == src) begin
            return mem_data;
        end else if (wb_we && wb_rd == src) begin
            return wb_data;
        end
        return rf_data;
    endfunction

    assign READ_REG_1 = ID_RS1;
    assign READ_REG_2 = ID_RS2;

    // Operand selection and load-use hazard detection.
    always_comb begin
        logic ex_fwd_ok;
        ex_fwd_ok = ex_valid_q & ex_reg_write_q & ~ex_mem_read_q;
        op_a = sel_operand(ID_RS1, RF_DATA_1, ex_fwd_ok, ex_rd_q, EX_ALU_RESULT,
                           MEM_REG_WRITE, MEM_RD, MEM_DATA, WB_REG_WRITE, WB_RD, WB_DATA);
        op_b = sel_operand(ID_RS2, RF_DATA_2, ex_fwd_ok, ex_rd_q, EX_ALU_RESULT,
                           MEM_REG_WRITE, MEM_RD, MEM_DATA, WB_REG_WRITE, WB_RD, WB_DATA);
        haz  = ID_VALID & ex_valid_q & ex_mem_read_q & (ex_rd_q != 5'd0) &
               ((ID_USE_RS1 & (ID_RS1 == ex_rd_q)) | (ID_USE_RS2 & (ID_RS2 == ex_rd_q)));
    end

    assign STALL = haz & ~FLUSH;

    // Next EX slot: bubble on flush or hazard, otherwise latch the decode slot.
    always_comb begin
        ex_valid_d     = ex_valid_q;
        ex_reg_write_d = ex_reg_write_q;
        ex_mem_read_d  = ex_mem_read_q;
        ex_rd_d        = ex_rd_q;
        ex_op_a_d      = ex_op_a_q;
        ex_op_b_d      = ex_op_b_q;
        ex_imm_d       = ex_imm_q;
        ex_pc_d        = ex_pc_q;
        ex_ctrl_d      = ex_ctrl_q;
        stall_count_d  = stall_count_q;
        if (FLUSH || haz) begin
            // Data fields keep their old values; only the control bits are killed.
            ex_valid_d     = 1'b0;
            ex_reg_write_d = 1'b0;
            ex_mem_read_d  = 1'b0;
            if (!FLUSH && stall_count_q != {CNT_W{1'b1}}) begin
                stall_count_d = stall_count_q + 1'b1;
            end
        end else begin
            ex_valid_d     = ID_VALID;
            ex_reg_write_d = ID_REG_WRITE & ID_VALID;
            ex_mem_read_d  = ID_MEM_READ & ID_VALID;
            ex_rd_d        = ID_RD;
            ex_op_a_d      = op_a;
            ex_op_b_d      = op_b;
            ex_imm_d       = ID_IMM;
            ex_pc_d        = ID_PC;
            ex_ctrl_d      = ID_CTRL;
        end
    end

    // EX pipeline register and stall counter.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ex_valid_q     <= 1'b0;
            ex_reg_write_q <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            ex_rd_q        <= '0;
            ex_op_a_q      <= '0;
            ex_op_b_q      <= '0;
            ex_imm_q       <= '0;
            ex_pc_q        <= '0;
            ex_ctrl_q      <= '0;
            stall_count_q  <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_reg_write_q <= ex_reg_write_d;
            ex_mem_read_q  <= ex_mem_read_d;
            ex_rd_q        <= ex_rd_d;
            ex_op_a_q      <= ex_op_a_d;
            ex_op_b_q      <= ex_op_b_d;
            ex_imm_q       <= ex_imm_d;
            ex_pc_q        <= ex_pc_d;
            ex_ctrl_q      <= ex_ctrl_d;
            stall_count_q  <= stall_count_d;
        end
    end

    assign EX_VALID     = ex_valid_q;
    assign EX_REG_WRITE = ex_reg_write_q;
    assign EX_MEM_READ  = ex_mem_read_q;
    assign EX_RD        = ex_rd_q;
    assign EX_OP_A      = ex_op_a_q;
    assign EX_OP_B      = ex_op_b_q;
    assign EX_IMM       = ex_imm_q;
    assign EX_PC        = ex_pc_q;
    assign EX_CTRL      = ex_ctrl_q;
    assign STALL_COUNT  = stall_count_q;

endmodule
